// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and widths for the ALU and its op sequencer
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int SETTLE_W  = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: a/b/control in, result/zero out
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (control)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = a << b;
      OP_SHR:  result = a >> b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_seq_stats.sv
// rtl/alu_seq_stats.sv - saturating response/zero counters, used when ALU_SEQ_STATS_EN is defined
module alu_seq_stats #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rsp_fire,
  input  logic                 rsp_zero,
  output logic [CNT_WIDTH-1:0] stat_ops,
  output logic [CNT_WIDTH-1:0] stat_zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_zero <= '0;
    end else begin
      if (rsp_fire && (stat_ops != '1)) begin
        stat_ops <= stat_ops + 1'b1;
      end
      if (rsp_fire && rsp_zero && (stat_zero != '1)) begin
        stat_zero <= stat_zero + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives the ALU from a request channel and returns results on a response channel
// Optional statistics outputs are enabled by defining ALU_SEQ_STATS_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  input  logic             req_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_ops,
  output logic [CNT_WIDTH-1:0] stat_zero
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || CNT_WIDTH < 1) begin : g_param_check
    $error("alu_op_sequencer: illegal SETTLE_CYCLES or CNT_WIDTH");
  end

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [WIDTH-1:0]    acc;
  logic                accept;
  logic                capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // ALU inputs are only loaded on accept, so they stay put through DRIVE and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      settle_cnt  <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      acc         <= '0;
    end else begin
      if (accept) begin
        alu_a       <= req_chain ? acc : req_a;
        alu_b       <= req_b;
        alu_control <= req_op;
        settle_cnt  <= SETTLE_LOAD;
      end else if ((state == DRIVE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        acc        <= alu_result;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsp_fire  (rsp_valid && rsp_ready),
    .rsp_zero  (rsp_zero),
    .stat_ops  (stat_ops),
    .stat_zero (stat_zero)
  );
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench: SETTLE_CYCLES=1 instance plus a SETTLE_CYCLES=4 instance for reset-mid-op
// Stats checks are compiled in when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rst2_n;
  logic       req_valid;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [2:0] req_op;
  logic       req_chain;
  logic       rsp_ready;

  logic       req_ready1, rsp_valid1, rsp_zero1, busy1, alu_zero1;
  logic [7:0] alu_a1, alu_b1, alu_result1, rsp_result1;
  logic [2:0] alu_ctl1;
  logic       req_ready2, rsp_valid2, rsp_zero2, busy2, alu_zero2;
  logic [7:0] alu_a2, alu_b2, alu_result2, rsp_result2;
  logic [2:0] alu_ctl2;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops1, stat_zero1, stat_ops2, stat_zero2;
`endif

  exp_t q1[$];
  exp_t q2[$];
  int   n_cmp;
  int   n_mis;
  logic [7:0] acc1;
  int   exp_ops;
  int   exp_zero;

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_chain(req_chain),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_control(alu_ctl1),
    .alu_result(alu_result1), .alu_zero(alu_zero1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result1), .rsp_zero(rsp_zero1), .busy(busy1)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops1), .stat_zero(stat_zero1)
`endif
  );

  alu #(.WIDTH(8)) u_alu1 (
    .a(alu_a1), .b(alu_b1), .control(alu_ctl1), .result(alu_result1), .zero(alu_zero1)
  );

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(4), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_chain(req_chain),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_control(alu_ctl2),
    .alu_result(alu_result2), .alu_zero(alu_zero2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result2), .rsp_zero(rsp_zero2), .busy(busy2)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops2), .stat_zero(stat_zero2)
`endif
  );

  alu #(.WIDTH(8)) u_alu2 (
    .a(alu_a2), .b(alu_b2), .control(alu_ctl2), .result(alu_result2), .zero(alu_zero2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~a;
      3'd6:    r = a << b;
      default: r = a >> b;
    endcase
    return {(r == 8'd0), r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One op on dut1; stall>0 holds rsp_ready low that many cycles and pokes a request meanwhile.
  task automatic op1(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] op, input logic chain, input int stall);
    logic [7:0] ea;
    logic [8:0] m;
    exp_t       e;
    int         n;
    ea = chain ? acc1 : a;
    m  = model(ea, b, op);
    @(negedge clk);
    check({tag, " req_ready idle"}, req_ready1, 1);
    rsp_ready = (stall == 0);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_chain = chain;
    e.result = m[7:0]; e.zero = m[8];
    q1.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_a = 8'h5C; req_b = 8'hC5; req_op = 3'd7; req_chain = 1'b0;
    check({tag, " alu_a"}, alu_a1, ea);
    check({tag, " alu_b"}, alu_b1, b);
    check({tag, " alu_control"}, alu_ctl1, op);
    n = 0;
    while (!rsp_valid1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 1);
    for (int i = 0; i < stall; i++) begin
      check({tag, " stall rsp_valid"}, rsp_valid1, 1);
      check({tag, " stall req_ready"}, req_ready1, 0);
      check({tag, " stall rsp_result"}, rsp_result1, m[7:0]);
      check({tag, " stall alu_a"}, alu_a1, ea);
      if (i == 1) begin
        req_valid = 1'b1; req_a = 8'hEE; req_b = 8'h11; req_op = 3'd3;
      end
      if (i == 2) req_valid = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check({tag, " rsp_valid"}, rsp_valid1, 1);
    check({tag, " queue depth"}, q1.size(), 1);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check({tag, " rsp_result"}, rsp_result1, e.result);
      check({tag, " rsp_zero"}, rsp_zero1, e.zero);
    end
    exp_ops++;
    if (m[8]) exp_zero++;
    acc1 = m[7:0];
    @(negedge clk);
    check({tag, " rsp_valid cleared"}, rsp_valid1, 0);
    check({tag, " req_ready back"}, req_ready1, 1);
  endtask

  initial begin
    exp_t e;
    int   n;
    int   seen;
    n_cmp = 0; n_mis = 0; acc1 = 8'd0; exp_ops = 0; exp_zero = 0;
    rst_n = 1'b0; rst2_n = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_chain = 1'b0;
    rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset alu_a", alu_a1, 0);
    check("reset alu_b", alu_b1, 0);
    check("reset alu_control", alu_ctl1, 0);
    check("reset rsp_result", rsp_result1, 0);
    check("reset rsp_zero", rsp_zero1, 0);
    check("reset rsp_valid", rsp_valid1, 0);
    check("reset busy", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", req_ready1, 1);
`ifdef ALU_SEQ_STATS_EN
    check("reset stat_ops", stat_ops1, 0);
    check("reset stat_zero", stat_zero1, 0);
`endif

    op1("add 5+3", 8'd5, 8'd3, 3'd0, 1'b0, 0);
    op1("sub 7-7", 8'd7, 8'd7, 3'd1, 1'b0, 0);
    op1("add wrap", 8'd200, 8'd100, 3'd0, 1'b0, 0);
`ifdef ALU_SEQ_STATS_EN
    check("stat_ops after 3", stat_ops1, 3);
    check("stat_zero after 3", stat_zero1, 1);
`endif
    op1("add 10+20", 8'd10, 8'd20, 3'd0, 1'b0, 0);
    op1("chain add", 8'd99, 8'd5, 3'd0, 1'b1, 0);
    op1("xor backpressure", 8'hA5, 8'h5A, 3'd4, 1'b0, 5);
    op1("chain sub to zero", 8'h01, 8'hFF, 3'd1, 1'b1, 0);
    op1("shl", 8'd3, 8'd2, 3'd6, 1'b0, 0);
    op1("chain shr", 8'd0, 8'd1, 3'd7, 1'b1, 0);
    op1("not ff", 8'hFF, 8'h00, 3'd5, 1'b0, 0);
`ifdef ALU_SEQ_STATS_EN
    check("stat_ops final", stat_ops1, exp_ops);
    check("stat_zero final", stat_zero1, exp_zero);
`endif

    // Second instance: four-cycle settle, then reset while the op is in flight.
    rst_n = 1'b0;
    rst2_n = 1'b1;
    @(negedge clk);
    check("d2 req_ready", req_ready2, 1);
    req_valid = 1'b1; req_a = 8'd40; req_b = 8'd2; req_op = 3'd0; req_chain = 1'b0;
    e.result = 8'd42; e.zero = 1'b0;
    q2.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    check("d2 busy", busy2, 1);
    n = 0;
    while (!rsp_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("d2 latency", n, 4);
    check("d2 queue depth", q2.size(), 1);
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check("d2 rsp_result", rsp_result2, e.result);
      check("d2 rsp_zero", rsp_zero2, e.zero);
    end
    @(negedge clk);
    check("d2 req_ready back", req_ready2, 1);

    req_valid = 1'b1; req_a = 8'd0; req_b = 8'd1; req_op = 3'd0; req_chain = 1'b1;
    e.result = 8'd43; e.zero = 1'b0;
    q2.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_chain = 1'b0;
    check("d2 chain alu_a", alu_a2, 42);
    @(negedge clk);
    rst2_n = 1'b0;
    #1;
    check("d2 rst alu_a", alu_a2, 0);
    check("d2 rst alu_b", alu_b2, 0);
    check("d2 rst alu_control", alu_ctl2, 0);
    check("d2 rst rsp_result", rsp_result2, 0);
    check("d2 rst rsp_zero", rsp_zero2, 0);
    check("d2 rst rsp_valid", rsp_valid2, 0);
    check("d2 rst busy", busy2, 0);
    q2.delete();
`ifdef ALU_SEQ_STATS_EN
    check("d2 rst stat_ops", stat_ops2, 0);
`endif
    @(negedge clk);
    rst2_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid2) seen++;
    end
    check("d2 no response after reset", seen, 0);

    req_valid = 1'b1; req_a = 8'd77; req_b = 8'd7; req_op = 3'd0; req_chain = 1'b1;
    e.result = 8'd7; e.zero = 1'b0;
    q2.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_chain = 1'b0;
    check("d2 acc cleared alu_a", alu_a2, 0);
    n = 0;
    while (!rsp_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("d2 latency 2", n, 4);
    check("d2 queue depth 2", q2.size(), 1);
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check("d2 rsp_result 2", rsp_result2, e.result);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
